fpconv_int_mod: RTL and testbench
=================================

// Module: fpconv_int_mod
// PURPOSE
//  Float-to-integer converter; the inverse of the int-to-float path in the FP unit.
//  Takes an operand in the internal 82-bit register layout (single, double or extended)
//  and returns a 32- or 64-bit signed or unsigned integer, rounded per rmode, with flags.
//  Three-stage pipeline. Sits in the FP convert slot and shares its clkEn stall.
// PARAMETERS
//  BIAS       16'h7fff               internal exponent bias
//  INDEF_S64  64'h8000_0000_0000_0000 signed-64 invalid result
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset; synchronous, active-high
//  clkEn    in   1   pipeline advance; 0 = all stages hold
//  en       in   1   operand valid this cycle
//  A        in   82  operand, internal layout
//  atyp     in   2   `ptype_sngl / `ptype_dbl / `ptype_ext selects A layout
//  isS      in   1   1 = signed target, 0 = unsigned target
//  is32     in   1   1 = 32-bit target, zero-extended to 64
//  rmode    in   2   0 = nearest-even, 1 = down (-inf), 2 = up (+inf), 3 = truncate
//  res      out  64  integer result
//  fInv     out  1   invalid: NaN, Inf, or out of range
//  fInx     out  1   inexact: nonzero fraction discarded
//  alt      out  1   result valid
// BEHAVIOUR
//  Reset: res = 0, fInv = 0, fInx = 0, alt = 0. All stage-valid bits clear; in-flight ops are dropped.
//  Latency: 3 advancing cycles, en -> alt. clkEn = 0 freezes every stage, including alt and res.
//  Unpack (s = sign, e = exponent field, m = 64-bit mantissa, bit 63 = integer bit):
//   SNG: s = A[31], b = A[32], E = {b, {7{~b}}, A[30:23]},  m = {1, A[22:0], 40'b0}
//   DBL: s = A[64], b = A[65], E = {b, {4{~b}}, A[63:53]},  m = {1, A[52:33], A[31:0], 11'b0}
//   EXT: s = A[81], E = {A[65], A[80:66]},                  m = {A[64:33], A[31:0]}
//   In SNG and DBL, E = 0 with a zero fraction is zero; the implicit 1 is then suppressed.
//  Specials:
//   E = 16'hffff -> NaN or Inf: fInv = 1.
//   E = 0 -> zero or denormal: result 0. fInx = 1 if m != 0, subject to the directed rounding below.
//  Exponent n = E - BIAS (signed 17-bit).
//   n < 0: integer part 0; guard/sticky come from m.
//   n >= 0: magnitude = m >> (63 - n); guard = next bit down; sticky = OR of the rest.
//   Shift is 2-level: byte select (n[5:3]), then bit (n[2:0]).
//   n > 63: out of range, skip the shift.
//  Rounding, applied to the magnitude before sign:
//   RNE: increment if guard & (sticky | lsb).
//   Down: increment if s & (guard | sticky).
//   Up: increment if ~s & (guard | sticky).
//   Truncate: never increment.
//   fInx = guard | sticky.
//  Range check after rounding; lim = is32 ? 31 : 63.
//   Signed: magnitude must be <= 2^lim - 1 when s = 0, and <= 2^lim when s = 1.
//   Unsigned: magnitude must be < 2^(lim+1) when s = 0. With s = 1 only a rounded magnitude of 0 is legal.
//   Unsigned -0.3 truncates to 0 with fInx = 1 and is not invalid.
//  Result: s & isS -> two's-complement negate of the magnitude; is32 -> upper 32 bits forced 0.
//  On invalid: res = INDEF. Signed: 64'h8000_0000_0000_0000, or 64'h0000_0000_8000_0000 when is32.
//   Unsigned: all ones at the target width. fInx = 0 whenever fInv = 1.
//  Stages:
//   S1: unpack, classify, compute n.
//   S2: shift, guard/sticky.
//   S3: round, range check, negate, select.
//  Per-op controls (isS, is32, rmode, s) travel with the op.
//  Back-to-back ops issue one per cycle, with no bubbles.
//  en = 0 cycles propagate as alt = 0. res holds its last value when alt = 0.
// STRUCTURE
//  Shared package (struct.sv): `ptype_* codes (existing), FPCI_BIAS, FPCI_INDEF_S64/S32.
//  Add an FPCI_RM_* enum for rmode.
//  Sub-module fpconv_rshift: 64-bit right shifter, 2-level, producing magnitude, guard and sticky.
//  Increment and negate reuse the existing adder_inc.
// TESTING
//  1. EXT 2^62 + 0.5 (E = 0x803d), signed64, RNE -> res 0x4000_0000_0000_0000, fInx = 1, fInv = 0.
//  2. DBL -2.5, signed32, RNE -> 0x0000_0000_FFFF_FFFE. Same op with rmode = 1 -> 0x..FFFD.
//     fInx = 1 in both cases.
//  3. EXT -2^63, signed64 -> 0x8000_0000_0000_0000, fInv = 0.
//     EXT +2^63, signed64 -> INDEF, fInv = 1.
//  4. SNG NaN (b = 1, e = 0xff) with any target -> fInv = 1, res = INDEF.
//     SNG -0.3, unsigned64, trunc -> res 0, fInx = 1.
//  5. Three ops back to back, with clkEn = 0 for 2 cycles mid-flight -> 3 results in order.
//     alt pulses are delayed by exactly 2 cycles.
//  6. Assert rst for 1 cycle with 2 ops in flight -> alt = 0 the next cycles and no stale result.
//     The first new op appears 3 advancing cycles after its en.

Source files
------------

// File: rtl/fpconv_int_mod_pkg.sv
// Shared constants and types for the float-to-integer converter.
package fpconv_int_mod_pkg;

  // Operand layout codes for the atyp input
  localparam logic [1:0] PTYPE_SNGL = 2'd0;
  localparam logic [1:0] PTYPE_DBL  = 2'd1;
  localparam logic [1:0] PTYPE_EXT  = 2'd2;

  // Internal exponent bias and invalid-result patterns
  localparam logic [15:0] FPCI_BIAS      = 16'h7fff;
  localparam logic [63:0] FPCI_INDEF_S64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] FPCI_INDEF_S32 = 64'h0000_0000_8000_0000;

  // Rounding mode encoding
  typedef enum logic [1:0] {
    FPCI_RM_RNE   = 2'd0,
    FPCI_RM_DOWN  = 2'd1,
    FPCI_RM_UP    = 2'd2,
    FPCI_RM_TRUNC = 2'd3
  } fpci_rm_e;

  // Per-op controls that travel down the pipe with the operand
  typedef struct packed {
    logic     s;
    logic     is_s;
    logic     is_32;
    fpci_rm_e rm;
  } fpci_ctrl_t;

endpackage

// File: rtl/fpconv_int_mod_rshift.sv
// Two-level 64-bit right shifter (byte step, then bit step) that also
// returns the first discarded bit (guard) and the OR of the rest (sticky).
module fpconv_int_mod_rshift (
  input  logic [63:0] data,
  input  logic [5:0]  amt,
  output logic [63:0] mag,
  output logic        guard,
  output logic        sticky
);

  // Data sits in the top half of a 128-bit window so shifted-out bits survive
  logic [127:0] byte_opts [8];
  logic [127:0] bit_opts  [8];
  logic [127:0] byte_sel;
  logic [127:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lvl
      assign byte_opts[gi] = {data, 64'b0} >> (8 * gi);
      assign bit_opts[gi]  = byte_sel >> gi;
    end
  endgenerate

  assign byte_sel = byte_opts[amt[5:3]];
  assign shifted  = bit_opts[amt[2:0]];

  assign mag    = shifted[127:64];
  assign guard  = shifted[63];
  assign sticky = |shifted[62:0];

endmodule

// File: rtl/fpconv_int_mod.sv
// Three-stage float-to-integer converter: unpack, align, round/range/select.
module fpconv_int_mod
  import fpconv_int_mod_pkg::*;
#(
  parameter logic [15:0] BIAS      = FPCI_BIAS,
  parameter logic [63:0] INDEF_S64 = FPCI_INDEF_S64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic        en,
  input  logic [81:0] A,
  input  logic [1:0]  atyp,
  input  logic        isS,
  input  logic        is32,
  input  logic [1:0]  rmode,
  output logic [63:0] res,
  output logic        fInv,
  output logic        fInx,
  output logic        alt
);

  // Stage 1 state
  logic        v1_reg, nan1_reg;
  fpci_ctrl_t  ctrl1_reg;
  logic [63:0] m1_reg;
  logic [16:0] n1_reg;       // two's complement, bit 16 = negative
  // Stage 2 state
  logic        v2_reg, inv2_reg, g2_reg, st2_reg;
  fpci_ctrl_t  ctrl2_reg;
  logic [63:0] mag2_reg;
  // Output state
  logic        alt_reg, inv_reg, inx_reg;
  logic [63:0] res_reg;

  // Unpack the operand according to its layout and compute the unbiased exponent
  logic        s_u;
  logic [15:0] e_u;
  logic [63:0] m_u;
  always_comb begin
    s_u = A[81];
    e_u = {A[65], A[80:66]};
    m_u = {A[64:33], A[31:0]};
    case (atyp)
      PTYPE_SNGL: begin
        s_u = A[31];
        e_u = {A[32], {7{~A[32]}}, A[30:23]};
        m_u = {1'b1, A[22:0], 40'b0};
        if (e_u == 16'h0 && A[22:0] == 23'h0) m_u = 64'h0;
      end
      PTYPE_DBL: begin
        s_u = A[64];
        e_u = {A[65], {4{~A[65]}}, A[63:53]};
        m_u = {1'b1, A[52:33], A[31:0], 11'b0};
        if (e_u == 16'h0 && A[52:33] == 20'h0 && A[31:0] == 32'h0) m_u = 64'h0;
      end
      default: ;
    endcase
  end

  // Stage 1 registers: unpacked operand, special-value class, exponent
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      nan1_reg  <= 1'b0;
      ctrl1_reg <= '0;
      m1_reg    <= '0;
      n1_reg    <= '0;
    end else if (clkEn) begin
      v1_reg    <= en;
      nan1_reg  <= (e_u == 16'hffff);
      ctrl1_reg <= '{s: s_u, is_s: isS, is_32: is32, rm: fpci_rm_e'(rmode)};
      m1_reg    <= m_u;
      n1_reg    <= {1'b0, e_u} - {1'b0, BIAS};
    end
  end

  // Alignment: shift by 63 - n, which for 0 <= n <= 63 is ~n[5:0]
  logic [63:0] sh_mag;
  logic        sh_g, sh_st;
  fpconv_int_mod_rshift u_rshift (
    .data   (m1_reg),
    .amt    (~n1_reg[5:0]),
    .mag    (sh_mag),
    .guard  (sh_g),
    .sticky (sh_st)
  );

  // Pick the integer part and guard/sticky for negative, in-range and huge exponents
  logic [63:0] mag_a;
  logic        g_a, st_a, inv_a;
  always_comb begin
    mag_a = 64'h0;
    g_a   = 1'b0;
    st_a  = 1'b0;
    inv_a = nan1_reg | (~n1_reg[16] & (|n1_reg[15:6]));
    if (n1_reg[16]) begin
      // Pure fraction: only n = -1 puts the top mantissa bit at the half position
      if (n1_reg == 17'h1ffff) begin
        g_a  = m1_reg[63];
        st_a = |m1_reg[62:0];
      end else begin
        st_a = |m1_reg;
      end
    end else if (!inv_a) begin
      mag_a = sh_mag;
      g_a   = sh_g;
      st_a  = sh_st;
    end
  end

  // Stage 2 registers: aligned magnitude and rounding bits
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg    <= 1'b0;
      inv2_reg  <= 1'b0;
      g2_reg    <= 1'b0;
      st2_reg   <= 1'b0;
      ctrl2_reg <= '0;
      mag2_reg  <= '0;
    end else if (clkEn) begin
      v2_reg    <= v1_reg;
      inv2_reg  <= inv_a;
      g2_reg    <= g_a;
      st2_reg   <= st_a;
      ctrl2_reg <= ctrl1_reg;
      mag2_reg  <= mag_a;
    end
  end

  // Round, range-check against the target width, negate and select the result
  logic        inc;
  logic [64:0] mag_r, lim_pow;
  logic        in_range, inv_f;
  logic [63:0] val, res_next;
  always_comb begin
    case (ctrl2_reg.rm)
      FPCI_RM_RNE:  inc = g2_reg & (st2_reg | mag2_reg[0]);
      FPCI_RM_DOWN: inc = ctrl2_reg.s & (g2_reg | st2_reg);
      FPCI_RM_UP:   inc = ~ctrl2_reg.s & (g2_reg | st2_reg);
      default:      inc = 1'b0;
    endcase
    mag_r   = {1'b0, mag2_reg} + {64'h0, inc};
    lim_pow = ctrl2_reg.is_32 ? (65'h1 << 31) : (65'h1 << 63);
    if (ctrl2_reg.is_s)
      in_range = ctrl2_reg.s ? (mag_r <= lim_pow) : (mag_r < lim_pow);
    else
      in_range = ctrl2_reg.s ? (mag_r == 65'h0) : (mag_r < (lim_pow << 1));
    inv_f = inv2_reg | ~in_range;

    val = mag_r[63:0];
    if (ctrl2_reg.s && ctrl2_reg.is_s) val = ~val + 64'h1;
    if (ctrl2_reg.is_32) val[63:32] = 32'h0;

    res_next = val;
    if (inv_f) begin
      if (ctrl2_reg.is_s)
        res_next = ctrl2_reg.is_32 ? FPCI_INDEF_S32 : INDEF_S64;
      else
        res_next = ctrl2_reg.is_32 ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    end
  end

  // Output registers: result and flags update only for valid ops
  always_ff @(posedge clk) begin
    if (rst) begin
      alt_reg <= 1'b0;
      res_reg <= '0;
      inv_reg <= 1'b0;
      inx_reg <= 1'b0;
    end else if (clkEn) begin
      alt_reg <= v2_reg;
      if (v2_reg) begin
        res_reg <= res_next;
        inv_reg <= inv_f;
        inx_reg <= (g2_reg | st2_reg) & ~inv_f;
      end
    end
  end

  assign res  = res_reg;
  assign fInv = inv_reg;
  assign fInx = inx_reg;
  assign alt  = alt_reg;

endmodule

// File: tb/tb_fpconv_int_mod.sv
// Directed-vector bench for the float-to-integer converter.
module tb_fpconv_int_mod;

  logic        clk = 1'b0;
  logic        rst, clkEn, en, isS, is32;
  logic [81:0] A;
  logic [1:0]  atyp, rmode;
  logic [63:0] res;
  logic        fInv, fInx, alt;

  int n_checks = 0;
  int n_fail   = 0;

  fpconv_int_mod dut (
    .clk   (clk),
    .rst   (rst),
    .clkEn (clkEn),
    .en    (en),
    .A     (A),
    .atyp  (atyp),
    .isS   (isS),
    .is32  (is32),
    .rmode (rmode),
    .res   (res),
    .fInv  (fInv),
    .fInx  (fInx),
    .alt   (alt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [81:0] mk_ext(input logic s, input logic [15:0] e, input logic [63:0] m);
    return {s, e[14:0], e[15], m[63:32], 1'b0, m[31:0]};
  endfunction

  function automatic logic [81:0] mk_dbl(input logic s, input logic b, input logic [10:0] e, input logic [51:0] f);
    return {16'h0, b, s, e, f[51:32], 1'b0, f[31:0]};
  endfunction

  function automatic logic [81:0] mk_sng(input logic s, input logic b, input logic [7:0] e, input logic [22:0] f);
    return {49'h0, b, s, e, f};
  endfunction

  task automatic drive(input logic [81:0] a, input logic [1:0] t, input logic s, input logic i32,
                       input logic [1:0] rm);
    A = a; atyp = t; isS = s; is32 = i32; rmode = rm; en = 1'b1;
  endtask

  // Issue one op, then check alt timing and the result on the third advancing edge
  task automatic run_op(input string tag, input logic [81:0] a, input logic [1:0] t, input logic s,
                        input logic i32, input logic [1:0] rm, input logic [63:0] exp_res,
                        input logic exp_inv, input logic exp_inx);
    drive(a, t, s, i32, rm);
    tick();
    en = 1'b0;
    tick();
    check({tag, ".alt_early"}, {63'h0, alt}, 64'h0);
    tick();
    check({tag, ".alt"}, {63'h0, alt}, 64'h1);
    check({tag, ".res"}, res, exp_res);
    check({tag, ".fInv"}, {63'h0, fInv}, {63'h0, exp_inv});
    check({tag, ".fInx"}, {63'h0, fInx}, {63'h0, exp_inx});
    $display("op %s: res=%h fInv=%0b fInx=%0b", tag, res, fInv, fInx);
  endtask

  localparam logic [1:0] SN = 2'd0, DB = 2'd1, EX = 2'd2;

  logic [81:0] op_t1, op_m25d, op_p25e;

  initial begin
    rst = 1'b1; clkEn = 1'b1; en = 1'b0; A = '0; atyp = 2'd0; isS = 1'b0; is32 = 1'b0; rmode = 2'd0;
    op_t1   = mk_ext(1'b0, 16'h803d, 64'h8000_0000_0000_0001);
    op_m25d = mk_dbl(1'b1, 1'b1, 11'h0, 52'h4_0000_0000_0000);
    op_p25e = mk_ext(1'b0, 16'h8000, 64'ha000_0000_0000_0000);
    tick(); tick();
    rst = 1'b0;
    check("reset.alt", {63'h0, alt}, 64'h0);
    check("reset.res", res, 64'h0);
    check("reset.fInv", {63'h0, fInv}, 64'h0);
    check("reset.fInx", {63'h0, fInx}, 64'h0);

    run_op("ext_2p62_half", op_t1, EX, 1, 0, 2'd0, 64'h4000_0000_0000_0000, 0, 1);
    run_op("dbl_m2p5_rne", op_m25d, DB, 1, 1, 2'd0, 64'h0000_0000_ffff_fffe, 0, 1);
    run_op("dbl_m2p5_down", op_m25d, DB, 1, 1, 2'd1, 64'h0000_0000_ffff_fffd, 0, 1);
    run_op("ext_m2p63", mk_ext(1, 16'h803e, 64'h8000_0000_0000_0000), EX, 1, 0, 2'd0,
           64'h8000_0000_0000_0000, 0, 0);
    run_op("ext_p2p63_s64", mk_ext(0, 16'h803e, 64'h8000_0000_0000_0000), EX, 1, 0, 2'd0,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("sng_nan_s32", mk_sng(0, 1, 8'hff, 23'h40_0000), SN, 1, 1, 2'd0,
           64'h0000_0000_8000_0000, 1, 0);
    run_op("sng_nan_u64", mk_sng(0, 1, 8'hff, 23'h40_0000), SN, 0, 0, 2'd3,
           64'hffff_ffff_ffff_ffff, 1, 0);
    run_op("sng_m0p3_u64", mk_sng(1, 0, 8'hfd, 23'h19_999a), SN, 0, 0, 2'd3, 64'h0, 0, 1);
    run_op("ext_2p5_rne", op_p25e, EX, 1, 0, 2'd0, 64'h2, 0, 1);
    run_op("ext_2p5_up", op_p25e, EX, 1, 0, 2'd2, 64'h3, 0, 1);
    run_op("ext_3p5_rne", mk_ext(0, 16'h8000, 64'he000_0000_0000_0000), EX, 1, 0, 2'd0, 64'h4, 0, 1);
    run_op("ext_p2p63_u64", mk_ext(0, 16'h803e, 64'h8000_0000_0000_0000), EX, 0, 0, 2'd0,
           64'h8000_0000_0000_0000, 0, 0);
    run_op("ext_2p32_u32", mk_ext(0, 16'h801f, 64'h8000_0000_0000_0000), EX, 0, 1, 2'd0,
           64'h0000_0000_ffff_ffff, 1, 0);
    run_op("ext_m1_u64", mk_ext(1, 16'h7fff, 64'h8000_0000_0000_0000), EX, 0, 0, 2'd3,
           64'hffff_ffff_ffff_ffff, 1, 0);
    run_op("ext_denorm_up", mk_ext(0, 16'h0000, 64'h1), EX, 0, 0, 2'd2, 64'h1, 0, 1);

    // Three back-to-back ops with a two-cycle stall while the pipe is full
    drive(op_p25e, EX, 1, 0, 2'd0);
    tick();
    check("stall.alt_e1", {63'h0, alt}, 64'h0);
    drive(op_m25d, DB, 1, 1, 2'd1);
    tick();
    check("stall.alt_e2", {63'h0, alt}, 64'h0);
    drive(op_t1, EX, 1, 0, 2'd0);
    clkEn = 1'b0;
    tick();
    check("stall.alt_e3", {63'h0, alt}, 64'h0);
    tick();
    check("stall.alt_e4", {63'h0, alt}, 64'h0);
    check("stall.res_hold", res, 64'h1);
    clkEn = 1'b1;
    tick();
    en = 1'b0;
    check("stall.op1_alt", {63'h0, alt}, 64'h1);
    check("stall.op1_res", res, 64'h2);
    tick();
    check("stall.op2_alt", {63'h0, alt}, 64'h1);
    check("stall.op2_res", res, 64'h0000_0000_ffff_fffd);
    tick();
    check("stall.op3_alt", {63'h0, alt}, 64'h1);
    check("stall.op3_res", res, 64'h4000_0000_0000_0000);
    tick();
    check("stall.alt_done", {63'h0, alt}, 64'h0);
    $display("op stall: three results delivered");

    // Reset with two ops in flight drops them
    drive(op_p25e, EX, 1, 0, 2'd2);
    tick();
    drive(op_m25d, DB, 1, 1, 2'd0);
    tick();
    en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.alt_e3", {63'h0, alt}, 64'h0);
    check("rst.res", res, 64'h0);
    tick();
    check("rst.alt_e4", {63'h0, alt}, 64'h0);
    tick();
    check("rst.alt_e5", {63'h0, alt}, 64'h0);
    $display("op reset: in-flight ops dropped");
    run_op("post_rst", op_t1, EX, 1, 0, 2'd0, 64'h4000_0000_0000_0000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
